mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory word width.
REQ-003 SHALL have parameter TIMEOUT, default 64, max cycles spent in ISSUE+WAIT before abort (legal range 2..255).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have ports m0_req / m1_req  input  1  requester N access request, level.
REQ-007 SHALL have ports m0_wr / m1_wr  input  1  1=write, 0=read.
REQ-008 SHALL have ports m0_addr / m1_addr  input  ADDR_W  access address.
REQ-009 SHALL have ports m0_wdata / m1_wdata  input  DATA_W  write data.
REQ-010 SHALL have ports m0_ack / m1_ack  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports m0_err / m1_err  output  1  one-cycle timeout pulse, coincident with ack.
REQ-012 SHALL have ports m0_rdata / m1_rdata  output  DATA_W  registered read data, valid with ack.
REQ-013 SHALL have ports mem_req, mem_wr  output  1, mem_addr  output  ADDR_W, mem_wdata  output  DATA_W  memory command.
REQ-014 SHALL have ports mem_busy  input  1, mem_rdata  input  DATA_W  memory status/read data.
REQ-015 SHALL have port arb_busy  output  1  high in any state except IDLE.

Function
REQ-016 Requester SHALL hold req, wr, addr, wdata stable from assertion until the cycle of its ack; req still high after ack is a new request.
REQ-017 FSM SHALL have states IDLE, ISSUE, WAIT, DONE.
REQ-018 IDLE: when any req is high, SHALL select a winner, latch its wr/addr/wdata into command registers, and go to ISSUE at that edge.
REQ-019 Arbitration SHALL be round-robin: single request wins; with both high, the requester not granted last wins; last-grant pointer updates in DONE.
REQ-020 ISSUE: mem_req=1 with latched command; SHALL go to WAIT at the first edge where mem_busy==0 is sampled.
REQ-021 WAIT: mem_req=0; SHALL go to DONE at the first edge where mem_busy==0 is sampled, capturing mem_rdata into the winner's rdata register if read.
REQ-022 DONE: winner's ack=1 for exactly one cycle; SHALL return to IDLE at next edge; loser's ack/err stay 0.
REQ-023 Write access SHALL leave the winner's rdata register unchanged.
REQ-024 With mem_busy constantly 0, ack SHALL be high in the 3rd cycle after the IDLE cycle in which req was sampled; back-to-back throughput 1 access per 4 cycles.
REQ-025 Cycle counter SHALL clear on entry to ISSUE and increment each cycle in ISSUE/WAIT; reaching TIMEOUT SHALL force DONE with err=1, ack=1, rdata=0 for the winner.
REQ-026 mem_addr/mem_wdata/mem_wr SHALL be driven from command registers only; mem_req SHALL never be high outside ISSUE.
REQ-027 Requests arriving while arb_busy=1 SHALL be held pending, never dropped; winner's request change mid-access SHALL be ignored.

Reset
REQ-028 reset=0 SHALL immediately force IDLE, all ack/err/mem_req/mem_wr/arb_busy=0, mem_addr/mem_wdata/rdata registers=0, counter=0, last-grant pointer=m1 (so m0 wins first tie).
REQ-029 Reset mid-access SHALL abandon the access with no ack or err pulse.

Verification
REQ-030 mem_busy=0; m0 write addr 0x10 data 0xA5 -> mem_req one cycle with wr=1, addr 0x10, data 0xA5; m0_ack 3 cycles after sample, m0_err=0.
REQ-031 m0 read addr 0x10, memory returns 0xA5 with mem_busy high 10 cycles -> mem_req held until busy low; m0_ack with m0_rdata=0xA5.
REQ-032 m0_req and m1_req both held high after reset for 4 accesses -> grant order m0, m1, m0, m1; one ack per DONE.
REQ-033 mem_busy stuck 1, TIMEOUT=8 -> m1_ack and m1_err pulse together 8 cycles after ISSUE entry, m1_rdata=0, FSM back to IDLE.
REQ-034 reset pulled low during WAIT -> all outputs 0 asynchronously, no ack; after release, pending m1 request served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory port.
// Each access walks IDLE -> ISSUE -> WAIT -> DONE and is aborted with err after TIMEOUT cycles.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_busy,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              arb_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Counter value seen during the last permitted ISSUE/WAIT cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_r;
    logic              last_r;
    logic              win_r;
    logic [7:0]        cnt_r;
    logic              mem_req_r;
    logic              mem_wr_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              m0_ack_r;
    logic              m0_err_r;
    logic [DATA_W-1:0] m0_rdata_r;
    logic              m1_ack_r;
    logic              m1_err_r;
    logic [DATA_W-1:0] m1_rdata_r;
    logic              arb_busy_r;
    logic              grant_s;
    logic              timeout_s;

    // Round-robin pick: on a tie the requester not granted last time wins.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        logic pick;
        if (req0 && req1) begin
            pick = ~last;
        end else if (req1) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
        return pick;
    endfunction

    // Winner selection and timeout detection.
    always_comb begin
        grant_s   = rr_pick(m0_req, m1_req, last_r);
        timeout_s = 1'b0;
        if (cnt_r == CNT_LAST) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Access sequencer with registered command, handshake and read-data outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            last_r      <= 1'b1;
            win_r       <= 1'b0;
            cnt_r       <= 8'd0;
            mem_req_r   <= 1'b0;
            mem_wr_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            m0_ack_r    <= 1'b0;
            m0_err_r    <= 1'b0;
            m0_rdata_r  <= {DATA_W{1'b0}};
            m1_ack_r    <= 1'b0;
            m1_err_r    <= 1'b0;
            m1_rdata_r  <= {DATA_W{1'b0}};
            arb_busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    m0_ack_r <= 1'b0;
                    m0_err_r <= 1'b0;
                    m1_ack_r <= 1'b0;
                    m1_err_r <= 1'b0;
                    if (m0_req || m1_req) begin
                        win_r       <= grant_s;
                        mem_wr_r    <= grant_s ? m1_wr    : m0_wr;
                        mem_addr_r  <= grant_s ? m1_addr  : m0_addr;
                        mem_wdata_r <= grant_s ? m1_wdata : m0_wdata;
                        mem_req_r   <= 1'b1;
                        cnt_r       <= 8'd0;
                        arb_busy_r  <= 1'b1;
                        state_r     <= ST_ISSUE;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    cnt_r <= cnt_r + 8'd1;
                    if (timeout_s) begin
                        // Abort: complete with err and zeroed read data.
                        mem_req_r <= 1'b0;
                        state_r   <= ST_DONE;
                        if (win_r) begin
                            m1_ack_r   <= 1'b1;
                            m1_err_r   <= 1'b1;
                            m1_rdata_r <= {DATA_W{1'b0}};
                        end else begin
                            m0_ack_r   <= 1'b1;
                            m0_err_r   <= 1'b1;
                            m0_rdata_r <= {DATA_W{1'b0}};
                        end
                    end else if (!mem_busy) begin
                        if (state_r == ST_ISSUE) begin
                            mem_req_r <= 1'b0;
                            state_r   <= ST_WAIT;
                        end else begin
                            state_r <= ST_DONE;
                            if (win_r) begin
                                m1_ack_r <= 1'b1;
                                if (!mem_wr_r) begin
                                    m1_rdata_r <= mem_rdata;
                                end
                            end else begin
                                m0_ack_r <= 1'b1;
                                if (!mem_wr_r) begin
                                    m0_rdata_r <= mem_rdata;
                                end
                            end
                        end
                    end
                end
                ST_DONE: begin
                    m0_ack_r   <= 1'b0;
                    m0_err_r   <= 1'b0;
                    m1_ack_r   <= 1'b0;
                    m1_err_r   <= 1'b0;
                    last_r     <= win_r;
                    arb_busy_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    mem_req_r  <= 1'b0;
                    m0_ack_r   <= 1'b0;
                    m0_err_r   <= 1'b0;
                    m1_ack_r   <= 1'b0;
                    m1_err_r   <= 1'b0;
                    arb_busy_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_wr    = mem_wr_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign m0_ack    = m0_ack_r;
    assign m0_err    = m0_err_r;
    assign m0_rdata  = m0_rdata_r;
    assign m1_ack    = m1_ack_r;
    assign m1_err    = m1_err_r;
    assign m1_rdata  = m1_rdata_r;
    assign arb_busy  = arb_busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses queue expected acks and memory
// commands; monitors on the falling edge pop and compare.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          mem_busy = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    logic          m0_ack, m0_err, m1_ack, m1_err, mem_req, mem_wr, arb_busy;
    logic [DW-1:0] m0_rdata, m1_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          t_m0_ack, t_m0_err, t_m1_ack, t_m1_err, t_mem_req, t_mem_wr, t_arb_busy;
    logic [DW-1:0] t_m0_rdata, t_m1_rdata, t_mem_wdata;
    logic [AW-1:0] t_mem_addr;

    // use_to selects which instance the monitors observe (switched only while in reset)
    logic          use_to = 1'b0;
    logic          o_m0_ack, o_m0_err, o_m1_ack, o_m1_err, o_mem_req, o_mem_wr, o_arb_busy;
    logic [DW-1:0] o_m0_rdata, o_m1_rdata, o_mem_wdata;
    logic [AW-1:0] o_mem_addr;

    assign o_m0_ack    = use_to ? t_m0_ack    : m0_ack;
    assign o_m0_err    = use_to ? t_m0_err    : m0_err;
    assign o_m1_ack    = use_to ? t_m1_ack    : m1_ack;
    assign o_m1_err    = use_to ? t_m1_err    : m1_err;
    assign o_m0_rdata  = use_to ? t_m0_rdata  : m0_rdata;
    assign o_m1_rdata  = use_to ? t_m1_rdata  : m1_rdata;
    assign o_mem_req   = use_to ? t_mem_req   : mem_req;
    assign o_mem_wr    = use_to ? t_mem_wr    : mem_wr;
    assign o_mem_addr  = use_to ? t_mem_addr  : mem_addr;
    assign o_mem_wdata = use_to ? t_mem_wdata : mem_wdata;
    assign o_arb_busy  = use_to ? t_arb_busy  : arb_busy;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_busy(mem_busy), .mem_rdata(mem_rdata), .arb_busy(arb_busy)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) u_to (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(t_m0_ack), .m0_err(t_m0_err), .m0_rdata(t_m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(t_m1_ack), .m1_err(t_m1_err), .m1_rdata(t_m1_rdata),
        .mem_req(t_mem_req), .mem_wr(t_mem_wr), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
        .mem_busy(mem_busy), .mem_rdata(mem_rdata), .arb_busy(t_arb_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vecs = 0;
    int miss = 0;

    typedef struct {
        bit            port;
        logic [DW-1:0] rdata;
        bit            err;
        int            cyc;
    } ack_t;
    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            len;
    } cmd_t;
    ack_t ack_q[$];
    cmd_t cmd_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ack(input bit port, input logic [DW-1:0] rdata, input bit err, input int c);
        ack_t e;
        e.port = port; e.rdata = rdata; e.err = err; e.cyc = c;
        ack_q.push_back(e);
    endtask

    task automatic push_cmd(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input int len);
        cmd_t e;
        e.wr = wr; e.addr = addr; e.wdata = wdata; e.len = len;
        cmd_q.push_back(e);
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_m0_ack || o_m1_ack) break;
        end
        chk("ack_seen", o_m0_ack | o_m1_ack, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, {m0_ack, m1_ack, m0_err, m1_err, mem_req, mem_wr, arb_busy}, 7'b0);
        chk({tag, "_addr"}, mem_addr, 32'h0);
        chk({tag, "_data"}, {mem_wdata, m0_rdata, m1_rdata}, 24'h0);
    endtask

    // Ack monitor: every ack must match the head of the expected-response queue.
    initial begin
        ack_t e;
        forever begin
            @(negedge clk);
            if (o_m0_err && !o_m0_ack) chk("m0_err_without_ack", o_m0_ack, 1'b1);
            if (o_m1_err && !o_m1_ack) chk("m1_err_without_ack", o_m1_ack, 1'b1);
            if (o_m0_ack || o_m1_ack) begin
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", {o_m1_ack, o_m0_ack}, 2'b00);
                end else begin
                    e = ack_q.pop_front();
                    chk("ack_port", {o_m1_ack, o_m0_ack}, e.port ? 2'b10 : 2'b01);
                    chk("ack_cycle", cyc, e.cyc);
                    chk("ack_rdata", e.port ? o_m1_rdata : o_m0_rdata, e.rdata);
                    chk("ack_err", e.port ? o_m1_err : o_m0_err, e.err);
                end
            end
        end
    end

    // Memory command monitor: checks each mem_req pulse's command and length.
    initial begin
        cmd_t e, cur;
        logic prev = 1'b0;
        int   len = 0;
        forever begin
            @(negedge clk);
            if (o_mem_req && !o_arb_busy) chk("mem_req_while_idle", o_arb_busy, 1'b1);
            if (o_mem_req && !prev) begin
                cur.wr = o_mem_wr; cur.addr = o_mem_addr; cur.wdata = o_mem_wdata;
                len = 1;
            end else if (o_mem_req) begin
                len++;
            end else if (prev) begin
                if (cmd_q.size() == 0) begin
                    chk("unexpected_mem_cmd", prev, 1'b0);
                end else begin
                    e = cmd_q.pop_front();
                    chk("mem_wr", cur.wr, e.wr);
                    chk("mem_addr", cur.addr, e.addr);
                    chk("mem_wdata", cur.wdata, e.wdata);
                    chk("mem_req_len", len, e.len);
                end
            end
            prev = o_mem_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        reset = 1'b1;

        // m0 write, memory ready: single-cycle mem_req, ack three cycles after sampling
        edge1();
        m0_wr = 1'b1; m0_addr = 32'h10; m0_wdata = 8'hA5; m0_req = 1'b1;
        push_cmd(1'b1, 32'h10, 8'hA5, 1);
        push_ack(1'b0, 8'h00, 1'b0, cyc + 3);
        wait_ack(20);
        m0_req = 1'b0;

        // m0 read with memory busy for 10 cycles
        edge1();
        k = cyc;
        m0_wr = 1'b0; mem_rdata = 8'hA5; mem_busy = 1'b1; m0_req = 1'b1;
        push_cmd(1'b0, 32'h10, 8'hA5, 10);
        push_ack(1'b0, 8'hA5, 1'b0, k + 12);
        repeat (10) @(posedge clk);
        #1 mem_busy = 1'b0;
        wait_ack(20);
        m0_req = 1'b0;

        // m0 write must leave previously read data in place
        edge1();
        m0_wr = 1'b1; m0_addr = 32'h44; m0_wdata = 8'h3C; mem_rdata = 8'hFF; m0_req = 1'b1;
        push_cmd(1'b1, 32'h44, 8'h3C, 1);
        push_ack(1'b0, 8'hA5, 1'b0, cyc + 3);
        wait_ack(20);
        m0_req = 1'b0;

        // both held after reset: m0, m1, m0, m1 at one access per 4 cycles
        reset = 1'b0;
        #1 check_reset_outputs("reset_again");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        edge1();
        k = cyc;
        m0_wr = 1'b1; m0_addr = 32'h20; m0_wdata = 8'h11;
        m1_wr = 1'b0; m1_addr = 32'h30; m1_wdata = 8'h00;
        mem_rdata = 8'h5C; m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push_cmd(1'b1, 32'h20, 8'h11, 1);
            push_cmd(1'b0, 32'h30, 8'h00, 1);
            push_ack(1'b0, 8'h00, 1'b0, k + 3 + 8 * i);
            push_ack(1'b1, 8'h5C, 1'b0, k + 7 + 8 * i);
        end
        for (int i = 0; i < 4; i++) wait_ack(20);
        m0_req = 1'b0; m1_req = 1'b0;

        // TIMEOUT=8 instance: good read, then memory stuck busy
        reset = 1'b0;
        use_to = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        edge1();
        m1_wr = 1'b0; m1_addr = 32'h50; mem_rdata = 8'h77; mem_busy = 1'b0; m1_req = 1'b1;
        push_cmd(1'b0, 32'h50, 8'h00, 1);
        push_ack(1'b1, 8'h77, 1'b0, cyc + 3);
        wait_ack(20);
        m1_req = 1'b0;
        edge1();
        m1_addr = 32'h60; mem_busy = 1'b1; m1_req = 1'b1;
        push_cmd(1'b0, 32'h60, 8'h00, 8);
        push_ack(1'b1, 8'h00, 1'b1, cyc + 9);
        wait_ack(30);
        m1_req = 1'b0;
        @(negedge clk);
        chk("timeout_back_to_idle", o_arb_busy, 1'b0);

        // reset during WAIT abandons the access; pending m1 served after release
        reset = 1'b0;
        mem_busy = 1'b0;
        #1 use_to = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        edge1();
        m1_wr = 1'b0; m1_addr = 32'h70; mem_rdata = 8'h9E; m1_req = 1'b1;
        push_cmd(1'b0, 32'h70, 8'h00, 1);
        edge1();
        edge1();
        mem_busy = 1'b1;
        @(posedge clk);
        #3 reset = 1'b0;
        #1 check_reset_outputs("reset_in_wait");
        repeat (3) @(posedge clk);
        #1;
        mem_busy = 1'b0;
        reset = 1'b1;
        push_cmd(1'b0, 32'h70, 8'h00, 1);
        push_ack(1'b1, 8'h9E, 1'b0, cyc + 3);
        wait_ack(20);
        m1_req = 1'b0;

        repeat (3) @(negedge clk);
        chk("ack_queue_drained", ack_q.size(), 0);
        chk("cmd_queue_drained", cmd_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
